pulse_seq_ctrl: RTL and testbench
=================================

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 SHALL have ports: clk_sys  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have: cfg_we  in  1  config write strobe; cfg_addr  in  3  register select; cfg_data  in  22  write data (LSB-aligned).
REQ-004 SHALL have: go  in  1  start-sequence strobe; abort  in  1  terminate-sequence strobe.
REQ-005 SHALL have: clk_en_st1ms, clk_en_pluse, clk_en_scale, clk_en_scan, clk_en_noise  in  1 each  timer expiry ticks from timer_top.
REQ-006 SHALL have: datain_state_1ms  out  20; datain_pluse  out  20; datain_scale  out  22; datain_scan  out  20; datain_noise  out  20  timer reload values to timer_top.
REQ-007 SHALL have: start  out  5  one-cycle timer start strobes, bit0 st1ms, bit1 pluse, bit2 scale, bit3 scan, bit4 noise.
REQ-008 SHALL have: state_over  out  4  one-cycle phase-complete strobes (to timer_top state_over_in); busy  out  1; done  out  1  one-cycle; echo_idx  out  16  current echo number.

Function
REQ-009 Config map SHALL be: addr0 state_1ms, 1 pluse, 2 scale, 3 scan, 4 noise, 5 echo_cnt (cfg_data[15:0]); addr6/7 ignored.
REQ-010 Writes SHALL take effect next cycle and SHALL be ignored while busy=1.
REQ-011 datain_* SHALL be driven directly from the config registers.
REQ-012 FSM states SHALL be IDLE, WAIT1MS, PULSE, ACQ, GAP, NOISE, DONE.
REQ-013 IDLE + go with echo_cnt=0 SHALL pulse done next cycle and remain IDLE.
REQ-014 IDLE + go with echo_cnt>0 SHALL enter WAIT1MS, clear echo_idx, pulse start[0].
REQ-015 WAIT1MS + clk_en_st1ms SHALL enter PULSE, pulse start[1] and state_over[0].
REQ-016 PULSE + clk_en_pluse SHALL enter ACQ, pulse start[2] and state_over[1].
REQ-017 ACQ + clk_en_scale SHALL pulse state_over[2]; if echo_idx+1=echo_cnt go to NOISE (start[4]) or DONE per REQ-027, else increment echo_idx, enter GAP, pulse start[3].
REQ-018 GAP + clk_en_scan SHALL enter PULSE, pulse start[1] and state_over[3].
REQ-019 NOISE + clk_en_noise SHALL enter DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-020 start/state_over/done SHALL be registered, asserted the cycle after the triggering tick, never wider than one cycle.
REQ-021 clk_en_* ticks not belonging to the current state SHALL be ignored; go while busy SHALL be ignored.
REQ-022 abort in any non-IDLE state SHALL return to IDLE next cycle with no start, state_over or done pulse; abort coincident with a tick SHALL win.
REQ-023 busy SHALL be 1 in every state except IDLE; echo_idx SHALL hold its final value in IDLE until next accepted go.

Reset
REQ-024 rst SHALL force state IDLE, start=0, state_over=0, done=0, busy=0, echo_idx=0.
REQ-025 rst SHALL clear all config registers to 0 (datain_*=0, echo_cnt=0).
REQ-026 rst mid-sequence SHALL override abort and any tick.

Configuration
REQ-027 With PSEQ_NOISE_EN defined, the NOISE phase SHALL follow the last echo; without it, ACQ exits straight to DONE, start[4]=0, datain_noise=0, addr4 writes ignored.

Structure
REQ-028 Package pulse_seq_pkg SHALL hold the state enum, config address constants and widths (20, 22, 16).
REQ-029 Config register file SHALL be sub-module pulse_seq_regs; FSM stays in pulse_seq_ctrl.

Verification
REQ-030 echo_cnt=3, ticks 5 cycles after each start -> start order 0,1,2,3,1,2,3,1,2,(4),done; echo_idx ends 2.
REQ-031 echo_cnt=0, go -> done one cycle later, busy never 1, start stays 0.
REQ-032 abort in ACQ coincident with clk_en_scale -> IDLE next cycle, no state_over[2], no done.
REQ-033 clk_en_scale injected during WAIT1MS -> no transition, no strobes.
REQ-034 cfg write addr1=0x12345 while busy -> datain_pluse unchanged; after done, write -> 0x12345 next cycle.
REQ-035 rst asserted in GAP with go high -> all outputs 0 next cycle, go ignored that cycle.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer; PSEQ_NOISE_EN enables the trailing noise phase.
// Holds the FSM state enum, config register addresses, field widths and timer strobe bit positions.
package pulse_seq_pkg;

  localparam int TW      = 20;
  localparam int SCALE_W = 22;
  localparam int ECHO_W  = 16;
  localparam int CFG_W   = 22;

  localparam logic [2:0] ADDR_ST1MS = 3'd0;
  localparam logic [2:0] ADDR_PLUSE = 3'd1;
  localparam logic [2:0] ADDR_SCALE = 3'd2;
  localparam logic [2:0] ADDR_SCAN  = 3'd3;
  localparam logic [2:0] ADDR_NOISE = 3'd4;
  localparam logic [2:0] ADDR_ECHO  = 3'd5;

  localparam int T_ST1MS = 0;
  localparam int T_PLUSE = 1;
  localparam int T_SCALE = 2;
  localparam int T_SCAN  = 3;
  localparam int T_NOISE = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT1MS,
    S_PULSE,
    S_ACQ,
    S_GAP,
    S_NOISE,
    S_DONE
  } state_t;

endpackage

// File: rtl/pulse_seq_regs.sv
// Config register file feeding timer reload values; writes land next cycle, dropped while busy.
// Noise reload register only exists with PSEQ_NOISE_EN, otherwise datain_noise is tied low.
module pulse_seq_regs
  import pulse_seq_pkg::*;
(
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               busy,
  output logic [TW-1:0]      datain_state_1ms,
  output logic [TW-1:0]      datain_pluse,
  output logic [SCALE_W-1:0] datain_scale,
  output logic [TW-1:0]      datain_scan,
  output logic [TW-1:0]      datain_noise,
  output logic [ECHO_W-1:0]  echo_cnt
);

`ifdef PSEQ_NOISE_EN
  logic [TW-1:0] noise_q;
  assign datain_noise = noise_q;
`else
  assign datain_noise = '0;
`endif

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      datain_state_1ms <= '0;
      datain_pluse     <= '0;
      datain_scale     <= '0;
      datain_scan      <= '0;
      echo_cnt         <= '0;
`ifdef PSEQ_NOISE_EN
      noise_q          <= '0;
`endif
    end else if (cfg_we && !busy) begin
      case (cfg_addr)
        ADDR_ST1MS: datain_state_1ms <= cfg_data[TW-1:0];
        ADDR_PLUSE: datain_pluse     <= cfg_data[TW-1:0];
        ADDR_SCALE: datain_scale     <= cfg_data[SCALE_W-1:0];
        ADDR_SCAN:  datain_scan      <= cfg_data[TW-1:0];
`ifdef PSEQ_NOISE_EN
        ADDR_NOISE: noise_q          <= cfg_data[TW-1:0];
`endif
        ADDR_ECHO:  echo_cnt         <= cfg_data[ECHO_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Echo sequencer FSM driving timer_top: all strobes registered, one cycle after the triggering tick.
// No backpressure; abort beats any tick, rst beats everything. PSEQ_NOISE_EN adds the noise phase.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
(
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               go,
  input  logic               abort,
  input  logic               clk_en_st1ms,
  input  logic               clk_en_pluse,
  input  logic               clk_en_scale,
  input  logic               clk_en_scan,
  input  logic               clk_en_noise,
  output logic [TW-1:0]      datain_state_1ms,
  output logic [TW-1:0]      datain_pluse,
  output logic [SCALE_W-1:0] datain_scale,
  output logic [TW-1:0]      datain_scan,
  output logic [TW-1:0]      datain_noise,
  output logic [4:0]         start,
  output logic [3:0]         state_over,
  output logic               busy,
  output logic               done,
  output logic [ECHO_W-1:0]  echo_idx
);

  state_t            state;
  logic [ECHO_W-1:0] echo_cnt;
  logic              last_echo;

  pulse_seq_regs u_regs (
    .clk_sys          (clk_sys),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .busy             (busy),
    .datain_state_1ms (datain_state_1ms),
    .datain_pluse     (datain_pluse),
    .datain_scale     (datain_scale),
    .datain_scan      (datain_scan),
    .datain_noise     (datain_noise),
    .echo_cnt         (echo_cnt)
  );

  // Widened compare so echo_cnt = 0xFFFF cannot wrap.
  assign last_echo = ({1'b0, echo_idx} + 17'd1) == {1'b0, echo_cnt};

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= S_IDLE;
      start      <= '0;
      state_over <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      echo_idx   <= '0;
    end else begin
      start      <= '0;
      state_over <= '0;
      done       <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              if (echo_cnt == '0) begin
                done <= 1'b1;
              end else begin
                state          <= S_WAIT1MS;
                busy           <= 1'b1;
                echo_idx       <= '0;
                start[T_ST1MS] <= 1'b1;
              end
            end
          end
          S_WAIT1MS: begin
            if (clk_en_st1ms) begin
              state          <= S_PULSE;
              start[T_PLUSE] <= 1'b1;
              state_over[0]  <= 1'b1;
            end
          end
          S_PULSE: begin
            if (clk_en_pluse) begin
              state          <= S_ACQ;
              start[T_SCALE] <= 1'b1;
              state_over[1]  <= 1'b1;
            end
          end
          S_ACQ: begin
            if (clk_en_scale) begin
              state_over[2] <= 1'b1;
              if (last_echo) begin
`ifdef PSEQ_NOISE_EN
                state          <= S_NOISE;
                start[T_NOISE] <= 1'b1;
`else
                state <= S_DONE;
                done  <= 1'b1;
`endif
              end else begin
                state         <= S_GAP;
                echo_idx      <= echo_idx + 1'b1;
                start[T_SCAN] <= 1'b1;
              end
            end
          end
          S_GAP: begin
            if (clk_en_scan) begin
              state          <= S_PULSE;
              start[T_PLUSE] <= 1'b1;
              state_over[3]  <= 1'b1;
            end
          end
          S_NOISE: begin
            if (clk_en_noise) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          // done was raised on entry, so this cycle only has to release busy
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: script-queue reference model checked every cycle plus directed literal checks.
// Honours PSEQ_NOISE_EN the same way as the design.
module tb_pulse_seq_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst, cfg_we, go, abort;
  logic [2:0]  cfg_addr;
  logic [21:0] cfg_data;
  logic [4:0]  man_en, auto_en;
  logic [19:0] datain_state_1ms, datain_pluse, datain_scan, datain_noise;
  logic [21:0] datain_scale;
  logic [4:0]  start;
  logic [3:0]  state_over;
  logic        busy, done;
  logic [15:0] echo_idx;

  wire clk_en_st1ms = man_en[0] | auto_en[0];
  wire clk_en_pluse = man_en[1] | auto_en[1];
  wire clk_en_scale = man_en[2] | auto_en[2];
  wire clk_en_scan  = man_en[3] | auto_en[3];
  wire clk_en_noise = man_en[4] | auto_en[4];

  always #5 clk_sys = ~clk_sys;

  pulse_seq_ctrl dut (
    .clk_sys(clk_sys), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .go(go), .abort(abort),
    .clk_en_st1ms(clk_en_st1ms), .clk_en_pluse(clk_en_pluse), .clk_en_scale(clk_en_scale),
    .clk_en_scan(clk_en_scan), .clk_en_noise(clk_en_noise),
    .datain_state_1ms(datain_state_1ms), .datain_pluse(datain_pluse), .datain_scale(datain_scale),
    .datain_scan(datain_scan), .datain_noise(datain_noise),
    .start(start), .state_over(state_over), .busy(busy), .done(done), .echo_idx(echo_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted go expands into a script of (awaited tick -> strobes) steps.
  typedef struct {
    int         tk;
    logic [4:0] st;
    logic [3:0] so;
    bit         inc;
    bit         fin;
  } step_t;

  step_t       script[$];
  logic [21:0] m_cfg [0:7];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_idx = '0;
  logic [4:0]  m_start = '0;
  logic [3:0]  m_so = '0;
  logic [4:0]  m_tk;
  logic        m_was_busy;
  bit          chk_en = 1'b0;

  task automatic push_step(input int tk, input logic [4:0] st, input logic [3:0] so,
                           input bit inc, input bit fin);
    step_t s;
    s.tk = tk; s.st = st; s.so = so; s.inc = inc; s.fin = fin;
    script.push_back(s);
  endtask

  task automatic build_script(input int n);
    script.delete();
    push_step(0, 5'b00010, 4'b0001, 0, 0);
    for (int e = 0; e < n; e++) begin
      push_step(1, 5'b00100, 4'b0010, 0, 0);
      if (e < n - 1) begin
        push_step(2, 5'b01000, 4'b0100, 1, 0);
        push_step(3, 5'b00010, 4'b1000, 0, 0);
      end else begin
`ifdef PSEQ_NOISE_EN
        push_step(2, 5'b10000, 4'b0100, 0, 0);
        push_step(4, 5'b00000, 4'b0000, 0, 1);
`else
        push_step(2, 5'b00000, 4'b0100, 0, 1);
`endif
      end
    end
  endtask

  initial for (int i = 0; i < 8; i++) m_cfg[i] = '0;

  always @(posedge clk_sys) begin
    m_start = '0;
    m_so    = '0;
    m_done  = 1'b0;
    m_tk    = {clk_en_noise, clk_en_scan, clk_en_scale, clk_en_pluse, clk_en_st1ms};
    if (rst) begin
      script.delete();
      m_busy = 1'b0;
      m_idx  = '0;
      for (int i = 0; i < 8; i++) m_cfg[i] = '0;
    end else begin
      m_was_busy = m_busy;
      if (m_busy && abort) begin
        script.delete();
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (go) begin
          if (m_cfg[5][15:0] == 16'd0) m_done = 1'b1;
          else begin
            build_script(int'(m_cfg[5][15:0]));
            m_idx   = '0;
            m_busy  = 1'b1;
            m_start = 5'b00001;
          end
        end
      end else if (script.size() == 0) begin
        m_busy = 1'b0;
      end else if (m_tk[script[0].tk]) begin
        m_start = script[0].st;
        m_so    = script[0].so;
        if (script[0].inc) m_idx = m_idx + 16'd1;
        if (script[0].fin) m_done = 1'b1;
        void'(script.pop_front());
      end
      if (cfg_we && !m_was_busy) begin
        case (cfg_addr)
          3'd0, 3'd1, 3'd3: m_cfg[cfg_addr] = cfg_data & 22'h0FFFFF;
          3'd2:             m_cfg[2] = cfg_data;
`ifdef PSEQ_NOISE_EN
          3'd4:             m_cfg[4] = cfg_data & 22'h0FFFFF;
`endif
          3'd5:             m_cfg[5] = cfg_data & 22'h00FFFF;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("start", start, m_start);
      check("state_over", state_over, m_so);
      check("done", done, m_done);
      check("busy", busy, m_busy);
      check("echo_idx", echo_idx, m_idx);
      check("datain_state_1ms", datain_state_1ms, m_cfg[0]);
      check("datain_pluse", datain_pluse, m_cfg[1]);
      check("datain_scale", datain_scale, m_cfg[2]);
      check("datain_scan", datain_scan, m_cfg[3]);
      check("datain_noise", datain_noise, m_cfg[4]);
    end
  end

  // Timer stand-in: each start strobe yields its expiry tick 5 cycles later.
  bit auto_on = 1'b0;
  int cnt [0:4];
  initial begin
    auto_en = '0;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
  end
  always @(negedge clk_sys) begin
    for (int i = 0; i < 5; i++) begin
      auto_en[i] = 1'b0;
      if (!auto_on || rst) cnt[i] = 0;
      else begin
        if (cnt[i] > 0) begin
          cnt[i] = cnt[i] - 1;
          if (cnt[i] == 0) auto_en[i] = 1'b1;
        end
        if (start[i] === 1'b1) cnt[i] = 5;
      end
    end
  end

  bit log_en = 1'b0;
  int ev_log[$];
  always @(negedge clk_sys) begin
    if (log_en) begin
      for (int i = 0; i < 5; i++) if (start[i] === 1'b1) ev_log.push_back(i);
      if (done === 1'b1) ev_log.push_back(8);
    end
  end

  task automatic cfg_write(input logic [2:0] a, input logic [21:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk_sys);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk_sys);
    go = 1'b0;
  endtask

  task automatic pulse_tick(input int t);
    man_en[t] = 1'b1;
    @(negedge clk_sys);
    man_en = '0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk_sys);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

`ifdef PSEQ_NOISE_EN
  int exp_log[$] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 4, 8};
`else
  int exp_log[$] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 8};
`endif

  initial begin
    int k;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    go = 1'b0; abort = 1'b0; man_en = '0;
    repeat (2) @(negedge clk_sys);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_echo_idx", echo_idx, 0);
    check("rst_datain_pluse", datain_pluse, 0);
    rst = 1'b0;

    cfg_write(3'd0, 22'h00111);
    check("cfg_st1ms", datain_state_1ms, 32'h00111);
    cfg_write(3'd1, 22'h00222);
    cfg_write(3'd2, 22'h3ABCDE);
    check("cfg_scale_22bit", datain_scale, 32'h3ABCDE);
    cfg_write(3'd3, 22'h00333);
    cfg_write(3'd4, 22'h00444);
`ifdef PSEQ_NOISE_EN
    check("cfg_noise", datain_noise, 32'h00444);
`else
    check("cfg_noise_off", datain_noise, 32'h0);
`endif
    cfg_write(3'd6, 22'h3FFFFF);
    cfg_write(3'd5, 22'h3F0003);

    // three echoes with the timer stand-in answering every start
    auto_on = 1'b1; log_en = 1'b1;
    pulse_go();
    wait_done(400);
    @(negedge clk_sys);
    log_en = 1'b0;
    check("seq_len", ev_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < ev_log.size(); i++)
      check($sformatf("seq_ev%0d", i), ev_log[i], exp_log[i]);
    check("final_echo_idx", echo_idx, 2);
    check("idle_after_done", busy, 0);

    // zero echoes: immediate done, never busy
    cfg_write(3'd5, 22'h0);
    pulse_go();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_start", start, 0);
    @(negedge clk_sys);
    check("zero_done_1cyc", done, 0);

    // foreign tick in WAIT1MS, then abort colliding with the scale tick
    auto_on = 1'b0;
    cfg_write(3'd5, 22'h2);
    pulse_go();
    check("go_start0", start, 5'b00001);
    pulse_tick(2);
    check("foreign_tick_start", start, 0);
    check("foreign_tick_so", state_over, 0);
    check("foreign_tick_busy", busy, 1);
    pulse_tick(0);
    check("wait_exit_start", start, 5'b00010);
    check("wait_exit_so", state_over, 4'b0001);
    pulse_tick(1);
    check("acq_enter_start", start, 5'b00100);
    abort = 1'b1; man_en[2] = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0; man_en = '0;
    check("abort_busy", busy, 0);
    check("abort_so", state_over, 0);
    check("abort_done", done, 0);
    @(negedge clk_sys);
    check("abort_no_late_done", done, 0);

    // config writes are locked out while busy
    auto_on = 1'b1;
    pulse_go();
    repeat (3) @(negedge clk_sys);
    cfg_write(3'd1, 22'h12345);
    check("busy_write_dropped", datain_pluse, 32'h00222);
    wait_done(400);
    @(negedge clk_sys);
    cfg_write(3'd1, 22'h12345);
    check("idle_write_taken", datain_pluse, 32'h12345);

    // reset in GAP with go held high
    pulse_go();
    k = 0;
    while (start[3] !== 1'b1 && k < 200) begin
      @(negedge clk_sys);
      k++;
    end
    check("reached_gap", start[3], 1);
    rst = 1'b1; go = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0; go = 1'b0;
    check("gaprst_start", start, 0);
    check("gaprst_so", state_over, 0);
    check("gaprst_done", done, 0);
    check("gaprst_busy", busy, 0);
    check("gaprst_echo_idx", echo_idx, 0);
    check("gaprst_datain_scale", datain_scale, 0);
    @(negedge clk_sys);
    check("gaprst_go_ignored", busy, 0);
    repeat (10) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
